// File: rtl/shift_pkg.sv
// Shared types for the iterative right-shift/rotate unit.
package shift_pkg;

    // Operation encoding as seen on the op port.
    typedef enum logic [1:0] {
        SH_SRL = 2'd0,
        SH_SRA = 2'd1,
        SH_ROR = 2'd2,
        SH_ROL = 2'd3
    } shift_op_t;

    // Control states of the iterative unit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } srlc_state_t;

endpackage

// File: rtl/bsrc.sv
// Constant-amount right cyclic stage with fill: shifts right by b when s is set.
// The caller supplies the b incoming top bits.  For a rotate these are the low
// b bits of a; for a logical or arithmetic shift they are zero or the sign.
module bsrc #(
    parameter int N = 32,
    parameter int b = 1
) (
    input  logic [N-1:0] a,
    input  logic         s,
    input  logic [b-1:0] fill,
    output logic [N-1:0] z
);

    // Shift right by b with fill inserted on top, or pass the operand through.
    always_comb begin
        z = a;
        if (s) z = {fill, a[N-1:b]};
    end

endmodule

// File: rtl/srlc_iter.sv
// Iterative SRL/SRA/ROR/ROL unit, one power-of-two stage per clock.
// ROL runs as ROR by (N - sa) mod N, which is simply -sa in W bits.
module srlc_iter
    import shift_pkg::*;
#(
    parameter int N = 32,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [W-1:0] sa,
    input  shift_op_t    op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic         busy
);

    localparam logic [W-1:0] K_LAST = W'(W - 1);

    srlc_state_t state, state_n;
    logic [N-1:0] acc;
    logic [W-1:0] amt;
    logic [W-1:0] k;
    shift_op_t    op_r;
    logic         sign;
    logic [N-1:0] z_r;

    logic [W-1:0]        rol_amt;
    logic                rot;
    logic                fill_bit;
    logic [W-1:0][N-1:0] stage_z;

    assign rol_amt  = '0 - sa;
    assign rot      = (op_r == SH_ROR) || (op_r == SH_ROL);
    assign fill_bit = (op_r == SH_SRA) ? sign : 1'b0;

    // One stage per amount bit; the current stage is chosen by k.
    for (genvar i = 0; i < W; i++) begin : g_stage
        localparam int B = 1 << i;
        logic [B-1:0] fill;
        assign fill = rot ? acc[B-1:0] : {B{fill_bit}};
        bsrc #(.N(N), .b(B)) u_bsrc (
            .a    (acc),
            .s    (amt[i]),
            .fill (fill),
            .z    (stage_z[i])
        );
    end

    // State and datapath registers; the result is captured on the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            amt   <= '0;
            k     <= '0;
            op_r  <= SH_SRL;
            sign  <= 1'b0;
            z_r   <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc  <= a;
                        amt  <= (op == SH_ROL) ? rol_amt : sa;
                        op_r <= op;
                        sign <= a[N-1];
                        k    <= '0;
                    end
                end
                SHIFT: begin
                    acc <= stage_z[k];
                    k   <= k + 1'b1;
                    if (k == K_LAST) z_r <= stage_z[k];
                end
                default: ;
            endcase
        end
    end

    // Next-state and handshake decode; outputs depend on state only.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (k == K_LAST) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign z = z_r;

endmodule
